// File: rtl/move_input_ctrl_if.sv
// Handshake and cursor bundle between the keyboard input stage and the game FSM.
interface move_input_ctrl_if;
    logic [7:0] keycode;
    logic       enable;
    logic       new_round;
    logic       move_ack;
    logic [3:0] cursor_x;
    logic [3:0] cursor_y;
    logic       move_valid;
    logic [3:0] move_x;
    logic [3:0] move_y;

    // Game FSM / keyboard side: drives keys and control, consumes moves.
    modport master (
        output keycode, enable, new_round, move_ack,
        input  cursor_x, cursor_y, move_valid, move_x, move_y
    );

    // Input stage side: turns keys into a cursor and pending moves.
    modport slave (
        input  keycode, enable, new_round, move_ack,
        output cursor_x, cursor_y, move_valid, move_x, move_y
    );
endinterface

// File: rtl/move_input_ctrl.sv
// Keyboard input stage: edge-detected, auto-repeating wrap-around cursor
// with a valid/ack move handshake towards the game round FSM.
module move_input_ctrl #(
    parameter int GRID_W        = 10,
    parameter int GRID_H        = 10,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             CLK,
    input  logic             RESET,
    move_input_ctrl_if.slave bus
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOAD_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] LOAD_PERIOD = CW'(REPEAT_PERIOD);
    localparam logic [3:0]    X_MAX       = 4'(GRID_W - 1);
    localparam logic [3:0]    Y_MAX       = 4'(GRID_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_FIRE,
        S_RELEASE
    } state_t;

    typedef enum logic [2:0] {
        K_NONE,
        K_UP,
        K_DOWN,
        K_LEFT,
        K_RIGHT,
        K_FIRE
    } key_t;

    function automatic key_t decode(input logic [7:0] code);
        case (code)
            8'h1A:   return K_UP;
            8'h16:   return K_DOWN;
            8'h04:   return K_LEFT;
            8'h07:   return K_RIGHT;
            8'h28:   return K_FIRE;
            default: return K_NONE;
        endcase
    endfunction

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    key_r, key_prev;
    logic [3:0]    cx, cx_n, cy, cy_n;
    logic [3:0]    mx, mx_n, my, my_n;
    logic          mv, mv_n;

    key_t key_cur;
    logic key_changed;
    logic new_press;
    logic do_step;

    assign key_cur     = decode(key_r);
    assign key_changed = (key_r != key_prev);
    assign new_press   = key_changed && (key_cur != K_NONE);

    // Registers: key history, FSM state, repeat counter, cursor and move latch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_r    <= '0;
            key_prev <= '0;
            state    <= S_IDLE;
            cnt      <= '0;
            cx       <= '0;
            cy       <= '0;
            mv       <= 1'b0;
            mx       <= '0;
            my       <= '0;
        end else begin
            key_r    <= bus.keycode;
            key_prev <= key_r;
            state    <= state_n;
            cnt      <= cnt_n;
            cx       <= cx_n;
            cy       <= cy_n;
            mv       <= mv_n;
            mx       <= mx_n;
            my       <= my_n;
        end
    end

    // Next-state logic: key handling per state, cursor stepping, then new_round override.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cx_n    = cx;
        cy_n    = cy;
        mv_n    = mv;
        mx_n    = mx;
        my_n    = my;
        do_step = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (bus.enable && new_press) begin
                    if (key_cur == K_FIRE) begin
                        mv_n    = 1'b1;
                        mx_n    = cx;
                        my_n    = cy;
                        state_n = S_FIRE;
                    end else begin
                        do_step = 1'b1;
                        cnt_n   = LOAD_DELAY;
                        state_n = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (!bus.enable) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (key_changed) begin
                    // A change of key pre-empts the repeat timer entirely.
                    if (key_cur == K_NONE) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else if (key_cur == K_FIRE) begin
                        mv_n    = 1'b1;
                        mx_n    = cx;
                        my_n    = cy;
                        cnt_n   = '0;
                        state_n = S_FIRE;
                    end else begin
                        do_step = 1'b1;
                        cnt_n   = LOAD_DELAY;
                    end
                end else if (cnt <= CW'(1)) begin
                    do_step = 1'b1;
                    cnt_n   = LOAD_PERIOD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_FIRE: begin
                if (mv && bus.move_ack) begin
                    mv_n    = 1'b0;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (key_cur == K_NONE) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (do_step) begin
            case (key_cur)
                K_UP:    cy_n = (cy == 4'd0)  ? Y_MAX : cy - 4'd1;
                K_DOWN:  cy_n = (cy == Y_MAX) ? 4'd0  : cy + 4'd1;
                K_LEFT:  cx_n = (cx == 4'd0)  ? X_MAX : cx - 4'd1;
                K_RIGHT: cx_n = (cx == X_MAX) ? 4'd0  : cx + 4'd1;
                default: ;
            endcase
        end

        if (bus.new_round) begin
            cx_n    = '0;
            cy_n    = '0;
            mv_n    = 1'b0;
            cnt_n   = '0;
            state_n = S_IDLE;
        end
    end

    assign bus.cursor_x   = cx;
    assign bus.cursor_y   = cy;
    assign bus.move_valid = mv;
    assign bus.move_x     = mx;
    assign bus.move_y     = my;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboard bench for move_input_ctrl: expected cursor steps, move fires and
// move clears are queued with the edge they must appear on, and popped by a
// monitor whenever the corresponding output changes.
module tb_move_input_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [3:0]  x;
        logic [3:0]  y;
        int unsigned at;
    } exp_t;

    exp_t        exp_cur[$];
    exp_t        exp_mv[$];
    int unsigned exp_clr[$];

    move_input_ctrl_if bus ();

    move_input_ctrl #(
        .GRID_W       (10),
        .GRID_H       (10),
        .REPEAT_DELAY (4),
        .REPEAT_PERIOD(2)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cur(input logic [3:0] x, input logic [3:0] y, input int unsigned at);
        exp_t e;
        e.x = x; e.y = y; e.at = at;
        exp_cur.push_back(e);
    endtask

    task automatic push_mv(input logic [3:0] x, input logic [3:0] y, input int unsigned at);
        exp_t e;
        e.x = x; e.y = y; e.at = at;
        exp_mv.push_back(e);
    endtask

    // One-cycle key tap; the step (if any) lands two edges after driving.
    task automatic tap(input logic [7:0] code, input bit expect_step,
                       input logic [3:0] ex, input logic [3:0] ey);
        if (expect_step) push_cur(ex, ey, cyc + 2);
        bus.keycode = code;
        tick(1);
        bus.keycode = 8'h00;
        tick(4);
    endtask

    // Monitor: every output event must match the head of its queue.
    initial begin
        logic [3:0] p_cx, p_cy;
        logic       p_v;
        exp_t       e;
        int unsigned at;
        p_cx = '0; p_cy = '0; p_v = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.cursor_x !== p_cx || bus.cursor_y !== p_cy) begin
                    if (exp_cur.size() == 0) begin
                        check("cursor_unexpected_change", 1, 0);
                    end else begin
                        e = exp_cur.pop_front();
                        check("cursor_x", 32'(bus.cursor_x), 32'(e.x));
                        check("cursor_y", 32'(bus.cursor_y), 32'(e.y));
                        check("cursor_edge", cyc, e.at);
                    end
                end
                if (bus.move_valid && !p_v) begin
                    if (exp_mv.size() == 0) begin
                        check("move_unexpected_fire", 1, 0);
                    end else begin
                        e = exp_mv.pop_front();
                        check("move_x", 32'(bus.move_x), 32'(e.x));
                        check("move_y", 32'(bus.move_y), 32'(e.y));
                        check("move_edge", cyc, e.at);
                    end
                end
                if (!bus.move_valid && p_v) begin
                    if (exp_clr.size() == 0) begin
                        check("move_unexpected_clear", 1, 0);
                    end else begin
                        at = exp_clr.pop_front();
                        check("clear_edge", cyc, at);
                    end
                end
            end
            p_cx = bus.cursor_x;
            p_cy = bus.cursor_y;
            p_v  = bus.move_valid;
        end
    end

    initial begin
        int unsigned c;
        rst           = 1'b1;
        bus.keycode   = 8'h00;
        bus.enable    = 1'b1;
        bus.new_round = 1'b0;
        bus.move_ack  = 1'b0;
        tick(3);
        rst = 1'b0;

        check("rst_cursor_x", 32'(bus.cursor_x), 0);
        check("rst_cursor_y", 32'(bus.cursor_y), 0);
        check("rst_move_valid", 32'(bus.move_valid), 0);
        check("rst_move_x", 32'(bus.move_x), 0);
        check("rst_move_y", 32'(bus.move_y), 0);
        tick(1);
        mon_en = 1'b1;

        // Single step right, then nothing more.
        tap(8'h07, 1, 4'd1, 4'd0);
        tick(4);

        // Wrap in all four directions.
        tap(8'h04, 1, 4'd0, 4'd0);
        tap(8'h04, 1, 4'd9, 4'd0);
        tap(8'h1A, 1, 4'd9, 4'd9);
        tap(8'h07, 1, 4'd0, 4'd9);
        tap(8'h16, 1, 4'd0, 4'd0);

        // Auto-repeat: held 12 edges, steps at k+1, k+5, k+7, k+9, k+11.
        c = cyc;
        push_cur(4'd0, 4'd1, c + 2);
        push_cur(4'd0, 4'd2, c + 6);
        push_cur(4'd0, 4'd3, c + 8);
        push_cur(4'd0, 4'd4, c + 10);
        push_cur(4'd0, 4'd5, c + 12);
        bus.keycode = 8'h16;
        tick(12);
        bus.keycode = 8'h00;
        tick(6);
        check("repeat_cursor_y", 32'(bus.cursor_y), 5);

        // Move to (3,7) and fire with Enter held.
        tap(8'h07, 1, 4'd1, 4'd5);
        tap(8'h07, 1, 4'd2, 4'd5);
        tap(8'h07, 1, 4'd3, 4'd5);
        tap(8'h16, 1, 4'd3, 4'd6);
        tap(8'h16, 1, 4'd3, 4'd7);
        push_mv(4'd3, 4'd7, cyc + 2);
        bus.keycode = 8'h28;
        tick(3);
        check("fire_valid", 32'(bus.move_valid), 1);
        check("fire_move_x", 32'(bus.move_x), 3);
        tick(2);
        check("fire_stable_x", 32'(bus.move_x), 3);
        check("fire_stable_y", 32'(bus.move_y), 7);
        exp_clr.push_back(cyc + 1);
        bus.move_ack = 1'b1;
        tick(1);
        bus.move_ack = 1'b0;
        tick(5);
        check("no_refire_held", 32'(bus.move_valid), 0);
        bus.keycode = 8'h00;
        tick(3);
        push_mv(4'd3, 4'd7, cyc + 2);
        bus.keycode = 8'h28;
        tick(1);
        bus.keycode = 8'h00;
        tick(2);
        exp_clr.push_back(cyc + 1);
        bus.move_ack = 1'b1;
        tick(1);
        bus.move_ack = 1'b0;
        tick(3);

        // Enable low: keys ignored; raising enable under a held key does nothing.
        bus.enable = 1'b0;
        tap(8'h07, 0, 4'd0, 4'd0);
        tap(8'h28, 0, 4'd0, 4'd0);
        check("dis_cursor_x", 32'(bus.cursor_x), 3);
        check("dis_cursor_y", 32'(bus.cursor_y), 7);
        check("dis_move_valid", 32'(bus.move_valid), 0);
        bus.keycode = 8'h07;
        tick(3);
        bus.enable = 1'b1;
        tick(8);
        check("held_after_enable_x", 32'(bus.cursor_x), 3);
        bus.keycode = 8'h00;
        tick(3);
        tap(8'h07, 1, 4'd4, 4'd7);

        // Pending move at (5,5): survives enable low and direction keys,
        // then new_round together with ack drops it and homes the cursor.
        tap(8'h07, 1, 4'd5, 4'd7);
        tap(8'h1A, 1, 4'd5, 4'd6);
        tap(8'h1A, 1, 4'd5, 4'd5);
        push_mv(4'd5, 4'd5, cyc + 2);
        bus.keycode = 8'h28;
        tick(1);
        bus.keycode = 8'h00;
        tick(3);
        bus.enable = 1'b0;
        tick(3);
        check("fire_kept_disabled", 32'(bus.move_valid), 1);
        bus.enable = 1'b1;
        tap(8'h07, 0, 4'd0, 4'd0);
        check("fire_frozen_x", 32'(bus.cursor_x), 5);
        push_cur(4'd0, 4'd0, cyc + 1);
        exp_clr.push_back(cyc + 1);
        bus.new_round = 1'b1;
        bus.move_ack  = 1'b1;
        tick(1);
        bus.new_round = 1'b0;
        bus.move_ack  = 1'b0;
        tick(3);
        check("nr_move_valid", 32'(bus.move_valid), 0);
        check("nr_cursor_x", 32'(bus.cursor_x), 0);
        tap(8'h07, 1, 4'd1, 4'd0);

        // Reset in the middle of a held repeat drops it.
        push_cur(4'd1, 4'd1, cyc + 2);
        bus.keycode = 8'h16;
        tick(4);
        push_cur(4'd0, 4'd0, cyc + 1);
        rst         = 1'b1;
        bus.keycode = 8'h00;
        tick(1);
        rst = 1'b0;
        tick(10);
        check("mid_rst_cursor_y", 32'(bus.cursor_y), 0);

        check("leftover_cursor_events", exp_cur.size(), 0);
        check("leftover_fire_events", exp_mv.size(), 0);
        check("leftover_clear_events", exp_clr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/move_input_ctrl.md
# move_input_ctrl

Upstream input stage for the game round state machine. Turns raw USB keyboard keycodes into a wrap-around cursor on the GRID_W x GRID_H board, with edge-detected and auto-repeating cursor steps. Presents each confirmed target cell to the game FSM over a valid/ack handshake. The game FSM gates input with `enable` and re-homes the cursor at each round start with `new_round`.

## Interface
- GRID_W, 10, board columns (2..15)
- GRID_H, 10, board rows (2..15)
- REPEAT_DELAY, 25000000, cycles from the first step of a held direction key to its first repeat (>=1)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeats (>=1)

- CLK  in  1  clock
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK
- keycode  in  8  USB HID keycode of the currently held key; 0x00 = none
- enable  in  1  game FSM is accepting moves
- new_round  in  1  one-cycle pulse; cursor returns to (0,0)
- move_ack  in  1  game FSM consumed the pending move
- cursor_x  out  4  current cursor column, 0..GRID_W-1
- cursor_y  out  4  current cursor row, 0..GRID_H-1
- move_valid  out  1  a move is pending
- move_x  out  4  latched column of the pending move
- move_y  out  4  latched row of the pending move

## Operation
- Key map: 0x1A (W) is y-1. 0x16 (S) is y+1. 0x04 (A) is x-1. 0x07 (D) is x+1. 0x28 (Enter) is fire. All other codes are "no key".
- `keycode` is registered once into key_r. key_prev holds the previous key_r. A new press is key_r != key_prev with key_r a mapped code.
- Wrap-around:
  - x-1 at 0 gives GRID_W-1; x+1 at GRID_W-1 gives 0.
  - y-1 at 0 gives GRID_H-1; y+1 at GRID_H-1 gives 0.
- FSM states:
  - IDLE: no mapped key held.
    - On a new direction press: step the cursor, load the repeat counter with REPEAT_DELAY, go to HELD.
    - On a new Enter press: latch the cursor into move_x/move_y, set move_valid, go to FIRE.
  - HELD: the counter decrements each cycle.
    - Counter reaching 1 → step the cursor, reload with REPEAT_PERIOD, stay in HELD.
    - key_r changes to a different direction → treat as a new press: step, reload REPEAT_DELAY.
    - key_r changes to Enter → act as a new Enter press.
    - key_r changes to no key → IDLE.
  - FIRE: move_valid held high, cursor frozen, direction keys ignored. move_x/move_y are stable until ack.
    - move_ack high while move_valid high → clear move_valid, go to RELEASE.
  - RELEASE: wait until key_r is no key, then go to IDLE. Enter never auto-repeats, and directions held through the fire are not acted on.
- `enable` low:
  - In IDLE or HELD: all keys ignored, cursor holds, state forced to IDLE, counter cleared.
  - In FIRE: the pending move is not cancelled. move_valid stays high until acked.
- `new_round`:
  - Sets the cursor to (0,0) and forces the state to IDLE.
  - Clears move_valid, dropping any pending move.
  - Wins over a simultaneous step, fire or ack.
  - A key still held afterwards is not a new press until it changes.
- move_ack while move_valid is low: ignored.

## Timing
- Reset values:
  - cursor_x = 0, cursor_y = 0, move_valid = 0, move_x = 0, move_y = 0.
  - key_r = 0, key_prev = 0, state IDLE, counter 0.
- Reset mid-operation drops any pending move and repeat in progress.
- Latency:
  - `keycode` is sampled at edge k. The cursor shows the step after edge k+1.
  - For Enter, move_valid = 1 after edge k+1.
- Handshake: move_ack sampled high at edge m clears move_valid after edge m. Ack in the same cycle valid first rises is legal.
- Repeat: with a direction held continuously, steps occur at edge k+1, k+1+REPEAT_DELAY, then every REPEAT_PERIOD edges.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset with enable=1 and GRID_W=GRID_H=10 → outputs all 0. Apply keycode=0x07 for one cycle, then 0x00 → cursor_x=1 two edges after keycode was applied; no further change.
- Cursor at (0,0), press 0x04, release, then press 0x1A, release → cursor (9,0), then (9,9).
- REPEAT_DELAY=4, REPEAT_PERIOD=2, hold 0x16 for 12 cycles from (0,0) → steps at edges k+1, k+5, k+7, k+9, k+11; cursor_y=5.
- Cursor (3,7), hold 0x28 with move_ack=0 for 5 cycles → move_valid=1, move=(3,7), stable. Then move_ack=1 for one cycle → move_valid=0 next edge. Keep 0x28 held → no second fire. Release, then press 0x28 → fires again.
- enable=0, press 0x07 and 0x28 → cursor and move_valid unchanged. Raise enable while the key is still held → no action until the key changes.
- Move pending at (5,5), pulse new_round together with move_ack → cursor (0,0), move_valid=0, state IDLE.
